// File: rtl/exp_pulse_gen_pkg.sv
// Shared settings for the exponential pulse generator and its trapezoidal shaper partner.
// DECAY_SHIFT_v_4 = 6 pairs with the shaper's M_v_4 = 2^6 - 1 = 63.
package exp_pulse_gen_pkg;

   localparam int SIZE_FILTER_DATA = 16;
   localparam int DECAY_SHIFT_v_4  = 6;
   localparam int RISE_SHIFT_v_4   = 2;
   localparam int FRAC_BITS_v_4    = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RISE  = 2'd1,
      DECAY = 2'd2
   } state_t;

endpackage

// File: rtl/exp_pulse_gen_sat_add.sv
// Unsigned adder that clamps to MAX and flags when the clamp was applied.
module exp_pulse_gen_sat_add #(
   parameter int               WIDTH = 23,
   parameter logic [WIDTH-1:0] MAX   = '1
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_clip
);

   logic [WIDTH:0] w_full;

   // One extra bit keeps the carry so an overflow past 2^WIDTH is still caught.
   always_comb begin
      w_full = {1'b0, i_a} + {1'b0, i_b};
      if (w_full > {1'b0, MAX}) begin
         o_sum  = MAX;
         o_clip = 1'b1;
      end else begin
         o_sum  = w_full[WIDTH-1:0];
         o_clip = 1'b0;
      end
   end

endmodule

// File: rtl/exp_pulse_gen.sv
// Detector-like pulse synthesizer: linear rise over 2^RISE_SHIFT samples, then
// exponential decay acc -= acc >> DECAY_SHIFT. Triggers arriving during decay stack.
//
// state | meaning
// IDLE  | no pulse, accumulator held at zero, trigger accepted
// RISE  | adding step each sample, triggers ignored
// DECAY | exponential decay, a trigger restarts the rise on top of the tail
module exp_pulse_gen #(
   parameter int SIZE_FILTER_DATA = exp_pulse_gen_pkg::SIZE_FILTER_DATA,
   parameter int DECAY_SHIFT      = exp_pulse_gen_pkg::DECAY_SHIFT_v_4,
   parameter int RISE_SHIFT       = exp_pulse_gen_pkg::RISE_SHIFT_v_4,
   parameter int FRAC_BITS        = exp_pulse_gen_pkg::FRAC_BITS_v_4,
   parameter int BASELINE         = 0
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               ce,
   input  logic                               trig_valid,
   input  logic [SIZE_FILTER_DATA-2:0]        trig_amp,
   output logic                               trig_ready,
   output logic signed [SIZE_FILTER_DATA-1:0] output_data,
   output logic                               busy,
   output logic                               pileup,
   output logic                               sat
);

   import exp_pulse_gen_pkg::*;

   localparam int ACC_W = SIZE_FILTER_DATA - 1 + FRAC_BITS;
   localparam int CNT_W = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;
   localparam int OW    = SIZE_FILTER_DATA + 2;
   localparam logic [ACC_W-1:0]        ACC_MAX   = {{(SIZE_FILTER_DATA-1){1'b1}}, {FRAC_BITS{1'b0}}};
   localparam logic [CNT_W-1:0]        RISE_LAST = CNT_W'((1 << RISE_SHIFT) - 1);
   localparam logic signed [OW-1:0]    BASE_W    = OW'(BASELINE);
   localparam logic signed [OW-1:0]    OUT_MAX   = OW'((1 << (SIZE_FILTER_DATA-1)) - 1);
   localparam logic signed [OW-1:0]    OUT_MIN   = OW'(-(1 << (SIZE_FILTER_DATA-1)));
   localparam logic [SIZE_FILTER_DATA-1:0] BASE_OUT = SIZE_FILTER_DATA'(BASELINE);

   state_t                        r_state, w_state_nxt;
   logic [ACC_W-1:0]              r_acc, w_acc_nxt;
   logic [ACC_W-1:0]              r_step, w_step_nxt;
   logic [CNT_W-1:0]              r_rise_cnt, w_cnt_nxt;
   logic                          r_busy, r_pileup, r_sat;
   logic [SIZE_FILTER_DATA-1:0]   r_out;
   logic                          w_pileup_nxt, w_sat_nxt, w_accept, w_clip;
   logic [ACC_W-1:0]              w_sum, w_decay, w_step_new;
   logic signed [OW-1:0]          w_out_wide;
   logic [SIZE_FILTER_DATA-1:0]   w_out_sat;

   exp_pulse_gen_sat_add #(
      .WIDTH (ACC_W),
      .MAX   (ACC_MAX)
   ) u_sat_add (
      .i_a    (r_acc),
      .i_b    (r_step),
      .o_sum  (w_sum),
      .o_clip (w_clip)
   );

   assign trig_ready  = (r_state != RISE);
   assign w_accept    = trig_valid & trig_ready;
   assign w_decay     = r_acc >> DECAY_SHIFT;
   assign w_step_new  = {trig_amp, {FRAC_BITS{1'b0}}} >> RISE_SHIFT;
   assign output_data = r_out;
   assign busy        = r_busy;
   assign pileup      = r_pileup;
   assign sat         = r_sat;

   // Output sample: baseline plus integer part of the accumulator, clamped to the signed range.
   always_comb begin
      w_out_wide = BASE_W + $signed({3'b000, r_acc[ACC_W-1:FRAC_BITS]});
      if (w_out_wide > OUT_MAX)      w_out_sat = OUT_MAX[SIZE_FILTER_DATA-1:0];
      else if (w_out_wide < OUT_MIN) w_out_sat = OUT_MIN[SIZE_FILTER_DATA-1:0];
      else                           w_out_sat = w_out_wide[SIZE_FILTER_DATA-1:0];
   end

   // Next-state, accumulator and strobe logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_acc_nxt    = r_acc;
      w_step_nxt   = r_step;
      w_cnt_nxt    = r_rise_cnt;
      w_pileup_nxt = 1'b0;
      w_sat_nxt    = 1'b0;
      case (r_state)
         IDLE: begin
            w_acc_nxt = '0;
            if (w_accept) begin
               w_step_nxt  = w_step_new;
               w_cnt_nxt   = '0;
               w_state_nxt = RISE;
            end
         end
         RISE: begin
            w_acc_nxt = w_sum;
            w_sat_nxt = w_clip;
            w_cnt_nxt = r_rise_cnt + CNT_W'(1);
            if (r_rise_cnt == RISE_LAST) w_state_nxt = DECAY;
         end
         DECAY: begin
            // A new trigger takes priority over the end-of-pulse check.
            if (w_accept) begin
               w_acc_nxt    = r_acc - w_decay;
               w_step_nxt   = w_step_new;
               w_cnt_nxt    = '0;
               w_state_nxt  = RISE;
               w_pileup_nxt = 1'b1;
            end else if (w_decay == '0) begin
               w_acc_nxt   = '0;
               w_state_nxt = IDLE;
            end else begin
               w_acc_nxt = r_acc - w_decay;
            end
         end
         default: begin
            w_acc_nxt   = '0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and datapath registers; everything holds while ce is low except the strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_acc      <= '0;
         r_step     <= '0;
         r_rise_cnt <= '0;
         r_busy     <= 1'b0;
         r_pileup   <= 1'b0;
         r_sat      <= 1'b0;
         r_out      <= BASE_OUT;
      end else if (ce) begin
         r_state    <= w_state_nxt;
         r_acc      <= w_acc_nxt;
         r_step     <= w_step_nxt;
         r_rise_cnt <= w_cnt_nxt;
         r_busy     <= (w_state_nxt != IDLE);
         r_pileup   <= w_pileup_nxt;
         r_sat      <= w_sat_nxt;
         r_out      <= w_out_sat;
      end else begin
         r_pileup   <= 1'b0;
         r_sat      <= 1'b0;
      end
   end

endmodule

// File: doc/exp_pulse_gen.md
Name: exp_pulse_gen

Overview:
Synthesizes detector-like pulses (finite linear rise, exponential decay) as a continuous sample stream, one sample per enabled clock. It is the convolution-side counterpart of the trapezoidal shaper: it drives the shaper's input_data in simulation and on-chip self-test. Triggers arrive through a valid/ready handshake. Overlapping triggers stack (pile-up) with saturation.

Parameters:
- SIZE_FILTER_DATA, 16: sample width; output is signed two's complement.
- DECAY_SHIFT, 6: decay per sample is acc >> DECAY_SHIFT (tau ≈ 2^DECAY_SHIFT samples).
- RISE_SHIFT, 2: rise lasts 2^RISE_SHIFT samples.
- FRAC_BITS, 8: fractional bits in the internal accumulator.
- BASELINE, 0: signed offset added to every output sample.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- ce  in  1  sample enable; all state holds when low
- trig_valid  in  1  trigger request
- trig_amp  in  SIZE_FILTER_DATA-1  unsigned pulse amplitude in LSB
- trig_ready  out  1  trigger can be accepted
- output_data  out  SIZE_FILTER_DATA  signed sample stream
- busy  out  1  pulse in progress (state != IDLE)
- pileup  out  1  one-cycle strobe: trigger accepted during DECAY
- sat  out  1  one-cycle strobe: accumulator clipped this sample

Behaviour:
- Reset (async, active-low): state=IDLE, acc=0, step=0, rise_cnt=0, output_data=BASELINE, trig_ready=1, busy=0, pileup=0, sat=0. Reset mid-pulse aborts the pulse immediately.
- Accumulator width is SIZE_FILTER_DATA-1+FRAC_BITS, unsigned. ACC_MAX = (2^(SIZE_FILTER_DATA-1)-1) << FRAC_BITS.
- Trigger acceptance: a trigger is accepted on an edge with ce && trig_valid && trig_ready. trig_ready=1 in IDLE and DECAY, and 0 in RISE. It is combinational from state only, never from trig_valid.
- On acceptance: step = (trig_amp << FRAC_BITS) >> RISE_SHIFT; rise_cnt = 0; state becomes RISE. The accumulator is not modified on the accept edge.
- RISE, each ce edge:
  - acc = sat_add(acc, step); rise_cnt++.
  - When rise_cnt reaches 2^RISE_SHIFT-1 on this edge, the next state is DECAY.
  - trig_valid is ignored during RISE.
- DECAY, each ce edge:
  - acc = acc - (acc >> DECAY_SHIFT).
  - If (acc >> DECAY_SHIFT) == 0 before the update, acc=0 and state becomes IDLE.
  - If a trigger is accepted on the same edge, the trigger wins: the decay update still applies, step is loaded, state becomes RISE, and pileup=1 for that cycle.
- IDLE: acc held at 0.
- sat_add clamps the result to ACC_MAX and sets sat=1 for that cycle.
- Output register, on each ce edge: output_data = BASELINE + (acc_current >> FRAC_BITS), saturating to the signed range. This gives exactly one cycle of latency from acc to output.
- Pulse timing: the first nonzero output appears 2 ce edges after the accept edge.
- ce=0: no state, acc, or output change; pileup and sat are forced to 0.
- busy = (state != IDLE), registered together with state.

Decomposition:
- Shared package (package_settings_v_4.sv): SIZE_FILTER_DATA, DECAY_SHIFT_v_4, RISE_SHIFT_v_4, FRAC_BITS_v_4, and a state enum typedef {IDLE, RISE, DECAY}.
- Choose DECAY_SHIFT_v_4 so that the shaper's M_v_4 = 2^DECAY_SHIFT_v_4 - 1.
- One sub-module, sat_add: unsigned saturating adder with a clip flag, parameterized on width.

Test Plan:
1. Reset held 5 cycles, then released with ce=1 and no triggers -> output_data=0, busy=0, trig_ready=1 indefinitely.
2. Single pulse with trig_amp=1000 and defaults -> outputs after accept are 0, 250, 500, 750, 1000, 984, 968, ... Output decays monotonically to 0; busy falls when acc is cleared; trig_ready=0 for exactly 4 cycles.
3. Trigger held valid throughout RISE -> not accepted until DECAY. Then accepted with pileup=1 for one cycle, and the rise stacks on the decayed value (e.g. 984 -> ≈1234 ...).
4. Two pulses with trig_amp=30000 each, second accepted in DECAY -> output clips at 32767 with sat=1 strobe(s), and no wrap to negative.
5. ce toggled 1,0,1,0 during a pulse -> sequence identical to scenario 2, with each value held during ce=0 cycles.
6. Reset asserted mid-DECAY (output ≈ 500) -> output_data=BASELINE and busy=0 asynchronously. The next trigger produces the clean scenario-2 sequence.
